// File: rtl/mc_board_ctl.sv
// mc_board_ctl: board control for VM2-class boards.
// Generates the core clock-enable (slow-mode divider),
// the button-gated 50 Hz timer event and the startup
// vector / acknowledge for unaddressed (una) reads.
//
// Ports:
//   clk_p, rst_n      clock, async active-low reset
//   cpuslow, div_i    slow-mode select, period-1
//   clk_ena_o         core clock-enable
//   tick_i            raw 50 Hz timer level
//   btn_i, status_o   raw buttons, toggle states
//   evnt_o            timer event (gated by status_o[0])
//   vm_init_i         synchronous clear of una logic
//   una_i, istb_i     una read / vector read strobes
//   vec_i, virq_i,
//   iack_i            external vector source
//   vec_o, virq_o,
//   iack_o            vector interface to core
module mc_board_ctl #(
  parameter int              DIV_W    = 5,
  parameter int              NBTN     = 1,
  parameter logic [NBTN-1:0] BTN_INIT = {NBTN{1'b1}},
  parameter int              DEB_LEN  = 2,
  parameter logic [15:0]     STARTUP  = 16'o140001,
  parameter int              UNA_DLY  = 1
) (
  input  logic             clk_p,
  input  logic             rst_n,
  input  logic             cpuslow,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_ena_o,
  input  logic             tick_i,
  input  logic [NBTN-1:0]  btn_i,
  output logic [NBTN-1:0]  status_o,
  output logic             evnt_o,
  input  logic             vm_init_i,
  input  logic             una_i,
  input  logic             istb_i,
  input  logic [15:0]      vec_i,
  input  logic             virq_i,
  input  logic             iack_i,
  output logic [15:0]      vec_o,
  output logic             virq_o,
  output logic             iack_o
);

  localparam int UCW = $clog2(UNA_DLY + 1);

  // Divider. The >= compare wraps at once when div_i
  // is lowered below the current count.
  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt >= div_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  assign clk_ena_o = cpuslow ? (r_cnt == '0) : 1'b1;

  // Tick synchroniser and rising-edge strobe
  logic r_tick_m;
  logic r_tick_s;
  logic r_tick_d;
  logic r_tstb;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_m <= 1'b0;
      r_tick_s <= 1'b0;
      r_tick_d <= 1'b0;
      r_tstb   <= 1'b0;
    end else begin
      r_tick_m <= tick_i;
      r_tick_s <= r_tick_m;
      r_tick_d <= r_tick_s;
      r_tstb   <= r_tick_s & ~r_tick_d;
    end
  end

  assign evnt_o = r_tick_s & status_o[0];

  // Buttons: sync, tick-sampled debounce, toggle once
  // per press. The lock/toggle rule looks at the
  // post-shift value so a shift and a decision can
  // happen on the same edge.
  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    logic               r_m;
    logic               r_s;
    logic               r_lock;
    logic               r_st;
    logic [DEB_LEN-1:0] r_sh;
    logic [DEB_LEN-1:0] w_shl;
    logic [DEB_LEN-1:0] w_sh;

    assign w_shl = (r_sh << 1) | DEB_LEN'(r_s);
    assign w_sh  = r_tstb ? w_shl : r_sh;

    always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
        r_m    <= 1'b0;
        r_s    <= 1'b0;
        r_sh   <= '0;
        r_lock <= 1'b0;
        r_st   <= BTN_INIT[g];
      end else begin
        r_m  <= btn_i[g];
        r_s  <= r_m;
        r_sh <= w_sh;
        if ((&w_sh) && !r_lock) begin
          r_st   <= ~r_st;
          r_lock <= 1'b1;
        end else if (w_sh == '0) begin
          r_lock <= 1'b0;
        end
      end
    end

    assign status_o[g] = r_st;
  end

  // Una path
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } una_st_t;

  una_st_t        r_state;
  una_st_t        w_state_nxt;
  logic [UCW-1:0] r_ucnt;
  logic [UCW-1:0] w_ucnt_nxt;
  logic           r_una_irq;
  logic           w_req;

  assign w_req = istb_i & una_i;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ucnt    <= '0;
      r_una_irq <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ucnt    <= w_ucnt_nxt;
      r_una_irq <= vm_init_i ? 1'b0 : una_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ucnt_nxt  = r_ucnt;
    if (vm_init_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            w_state_nxt = S_WAIT;
            w_ucnt_nxt  = UCW'(UNA_DLY - 1);
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            w_state_nxt = S_IDLE;
          end else if (r_ucnt == '0) begin
            w_state_nxt = S_ACK;
          end else begin
            w_ucnt_nxt = r_ucnt - UCW'(1);
          end
        end
        S_ACK: begin
          w_state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (!istb_i) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign vec_o  = una_i ? STARTUP : vec_i;
  assign virq_o = virq_i | r_una_irq;
  assign iack_o = iack_i | (r_state == S_ACK);

endmodule

// File: tb/tb_mc_board_ctl.sv
// tb_mc_board_ctl: directed self-checking bench.
// Stimulus is one linear sequence; checks are asserts.
module tb_mc_board_ctl;

  localparam int DIV_W = 5;

  logic             clk_p = 1'b0;
  logic             rst_n;
  logic             cpuslow;
  logic [DIV_W-1:0] div_i;
  logic             clk_ena_o;
  logic             tick_i;
  logic [0:0]       btn_i;
  logic [0:0]       status_o;
  logic             evnt_o;
  logic             vm_init_i;
  logic             una_i;
  logic             istb_i;
  logic [15:0]      vec_i;
  logic             virq_i;
  logic             iack_i;
  logic [15:0]      vec_o;
  logic             virq_o;
  logic             iack_o;

  int n_err = 0;
  int n_chk = 0;

  mc_board_ctl #(
    .DIV_W   (DIV_W),
    .NBTN    (1),
    .BTN_INIT(1'b1),
    .DEB_LEN (2),
    .STARTUP (16'o140001),
    .UNA_DLY (2)
  ) dut (
    .clk_p    (clk_p),
    .rst_n    (rst_n),
    .cpuslow  (cpuslow),
    .div_i    (div_i),
    .clk_ena_o(clk_ena_o),
    .tick_i   (tick_i),
    .btn_i    (btn_i),
    .status_o (status_o),
    .evnt_o   (evnt_o),
    .vm_init_i(vm_init_i),
    .una_i    (una_i),
    .istb_i   (istb_i),
    .vec_i    (vec_i),
    .virq_i   (virq_i),
    .iack_i   (iack_i),
    .vec_o    (vec_o),
    .virq_o   (virq_o),
    .iack_o   (iack_o)
  );

  always #5 clk_p = ~clk_p;

  task automatic step(input int n);
    repeat (n) @(posedge clk_p);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One tick_i period: exactly one tstb, shift at the
  // 4th edge after the rising level.
  task automatic do_tick();
    tick_i = 1'b1;
    step(6);
    tick_i = 1'b0;
    step(6);
  endtask

  initial begin
    rst_n     = 1'b0;
    cpuslow   = 1'b0;
    div_i     = '0;
    tick_i    = 1'b0;
    btn_i     = 1'b0;
    vm_init_i = 1'b0;
    una_i     = 1'b0;
    istb_i    = 1'b0;
    vec_i     = 16'h1234;
    virq_i    = 1'b1;
    iack_i    = 1'b1;
    step(3);
    chk("rst_ena", 32'(clk_ena_o), 1);
    chk("rst_evnt", 32'(evnt_o), 0);
    chk("rst_status", 32'(status_o), 1);
    chk("rst_virq_pass", 32'(virq_o), 1);
    chk("rst_iack_pass", 32'(iack_o), 1);
    virq_i = 1'b0;
    iack_i = 1'b0;
    #1;
    chk("rst_virq", 32'(virq_o), 0);
    chk("rst_iack", 32'(iack_o), 0);
    rst_n = 1'b1;

    // Divider, period 22
    cpuslow = 1'b1;
    div_i   = 5'd21;
    chk("div_cnt0", 32'(clk_ena_o), 1);
    step(21);
    chk("div_cnt21", 32'(clk_ena_o), 0);
    step(1);
    chk("div_wrap", 32'(clk_ena_o), 1);
    begin
      int hi;
      hi = 0;
      for (int i = 0; i < 22; i++) begin
        step(1);
        if (clk_ena_o) hi++;
      end
      chk("div_per22", 32'(hi), 1);
    end
    step(10);
    chk("div_cnt10", 32'(clk_ena_o), 0);
    div_i = 5'd3;
    step(1);
    chk("div_lower_wrap", 32'(clk_ena_o), 1);
    step(3);
    chk("div4_cnt3", 32'(clk_ena_o), 0);
    step(1);
    chk("div4_wrap", 32'(clk_ena_o), 1);
    cpuslow = 1'b0;
    div_i   = '0;
    chk("fast_ena", 32'(clk_ena_o), 1);
    step(1);
    cpuslow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("div0_ena", 32'(clk_ena_o), 1);
    end

    // Timer event mirrors tick_i, 2 cycles late
    tick_i = 1'b1;
    step(1);
    chk("evnt_lat1", 32'(evnt_o), 0);
    step(1);
    chk("evnt_rise", 32'(evnt_o), 1);
    step(4);
    tick_i = 1'b0;
    step(1);
    chk("evnt_hold", 32'(evnt_o), 1);
    step(1);
    chk("evnt_fall", 32'(evnt_o), 0);
    step(4);

    // Press 3 ticks: toggles after the 2nd tstb
    btn_i = 1'b1;
    do_tick();
    chk("press_t1", 32'(status_o), 1);
    tick_i = 1'b1;
    step(3);
    chk("press_t2_pre", 32'(status_o), 1);
    step(1);
    chk("press_t2_tgl", 32'(status_o), 0);
    step(2);
    tick_i = 1'b0;
    step(6);
    tick_i = 1'b1;
    step(3);
    chk("evnt_gated", 32'(evnt_o), 0);
    step(3);
    tick_i = 1'b0;
    step(6);
    chk("press_t3", 32'(status_o), 0);

    // Release 2 ticks, press again
    btn_i = 1'b0;
    do_tick();
    do_tick();
    chk("release", 32'(status_o), 0);
    btn_i = 1'b1;
    do_tick();
    chk("repress_t1", 32'(status_o), 0);
    do_tick();
    chk("repress_t2", 32'(status_o), 1);

    // One-tick glitch is rejected
    btn_i = 1'b0;
    do_tick();
    do_tick();
    btn_i = 1'b1;
    do_tick();
    btn_i = 1'b0;
    do_tick();
    do_tick();
    chk("glitch", 32'(status_o), 1);

    // Long hold toggles exactly once
    btn_i = 1'b1;
    for (int i = 0; i < 10; i++) do_tick();
    chk("hold10", 32'(status_o), 0);
    btn_i = 1'b0;
    do_tick();
    do_tick();

    // Una pass-through
    chk("vec_pass", 32'(vec_o), 32'h1234);
    virq_i = 1'b1;
    iack_i = 1'b1;
    #1;
    chk("virq_pass", 32'(virq_o), 1);
    chk("iack_pass", 32'(iack_o), 1);
    virq_i = 1'b0;
    iack_i = 1'b0;

    // Una read, UNA_DLY=2
    una_i  = 1'b1;
    istb_i = 1'b1;
    #1;
    chk("una_vec", 32'(vec_o), 32'hC001);
    chk("una_virq_lag", 32'(virq_o), 0);
    step(1);
    chk("una_virq", 32'(virq_o), 1);
    chk("una_ack_c1", 32'(iack_o), 0);
    step(1);
    chk("una_ack_c2", 32'(iack_o), 0);
    step(1);
    chk("una_ack_c3", 32'(iack_o), 1);
    step(1);
    chk("una_ack_end", 32'(iack_o), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("una_no_repulse", 32'(iack_o), 0);
    end
    istb_i = 1'b0;
    step(1);
    chk("una_idle", 32'(iack_o), 0);
    una_i = 1'b0;
    step(1);
    chk("una_virq_clr", 32'(virq_o), 0);

    // vm_init during WAIT
    una_i  = 1'b1;
    istb_i = 1'b1;
    step(1);
    vm_init_i = 1'b1;
    step(1);
    chk("init_virq", 32'(virq_o), 0);
    chk("init_ack1", 32'(iack_o), 0);
    step(1);
    chk("init_ack2", 32'(iack_o), 0);
    step(1);
    chk("init_ack3", 32'(iack_o), 0);
    una_i     = 1'b0;
    istb_i    = 1'b0;
    vm_init_i = 1'b0;
    step(1);

    // istb_i dropped during WAIT
    una_i  = 1'b1;
    istb_i = 1'b1;
    step(1);
    istb_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("abort_ack", 32'(iack_o), 0);
    end
    una_i = 1'b0;
    step(1);

    // Async reset mid-debounce, mid-count, mid-HOLD
    btn_i = 1'b1;
    do_tick();
    cpuslow = 1'b1;
    div_i   = 5'd5;
    una_i   = 1'b1;
    istb_i  = 1'b1;
    step(4);
    chk("pre_rst_ena", 32'(clk_ena_o), 0);
    chk("pre_rst_status", 32'(status_o), 0);
    chk("pre_rst_virq", 32'(virq_o), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ena", 32'(clk_ena_o), 1);
    chk("arst_status", 32'(status_o), 1);
    chk("arst_virq", 32'(virq_o), 0);
    chk("arst_iack", 32'(iack_o), 0);
    chk("arst_evnt", 32'(evnt_o), 0);
    una_i  = 1'b0;
    istb_i = 1'b0;
    step(2);
    rst_n = 1'b1;
    do_tick();
    chk("post_rst_t1", 32'(status_o), 1);
    do_tick();
    chk("post_rst_t2", 32'(status_o), 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_board_ctl.md
# mc_board_ctl

Parametrised board-control block for VM2-class processor boards. It sits between the vm2_wb core and board I/O and generates:
- the core's clock-enable, with a runtime-programmable slow-mode divider;
- the `evnt` timer interrupt, gated by N debounced toggle buttons sampled on the 50 Hz tick inside the main clock domain;
- the startup vector and acknowledge for unaddressed (una) reads.

## Interface
Parameters:
- DIV_W, 5: width of divider counter and `div_i`.
- NBTN, 1: number of toggle-button channels.
- BTN_INIT, {NBTN{1'b1}}: reset value of `status_o`.
- DEB_LEN, 2: consecutive tick samples needed to accept a button level (≥1).
- STARTUP, 16'o140001: vector returned on una reads.
- UNA_DLY, 1: cycles from una request to acknowledge (≥1).

Ports:
- clk_p  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpuslow  in  1  1 = divided clock-enable, 0 = enable every cycle.
- div_i  in  DIV_W  slow-mode period minus 1.
- clk_ena_o  out  1  core clock-enable.
- tick_i  in  1  raw 50 Hz timer level (asynchronous).
- btn_i  in  NBTN  raw buttons, active high (asynchronous).
- status_o  out  NBTN  toggle states; bit 0 gates timer.
- evnt_o  out  1  timer event to core.
- vm_init_i  in  1  core bus init, synchronous clear of una logic.
- una_i  in  1  core unaddressed-read strobe.
- istb_i  in  1  core vector-read strobe.
- vec_i  in  16  external vector bus.
- virq_i  in  1  external vector interrupt request.
- iack_i  in  1  external vector acknowledge.
- vec_o  out  16  vector to core.
- virq_o  out  1  interrupt request to core.
- iack_o  out  1  vector acknowledge to core.

## Operation
Divider:
- Counter `cnt` (DIV_W bits) increments every cycle.
- If `cnt >= div_i`, `cnt` ← 0 instead. A lowered `div_i` takes effect without overrun.
- `clk_ena_o` = cpuslow ? (cnt == 0) : 1.
- With `div_i` = 0, `clk_ena_o` is constant 1.

Tick:
- 2-FF synchroniser on `tick_i` gives `tick_s`.
- A registered rising-edge detect gives the one-cycle strobe `tstb`.
- `evnt_o` = tick_s & status_o[0].

Buttons (per channel):
- 2-FF synchroniser feeds a DEB_LEN-bit shift register, which shifts only on `tstb`.
- When the register is all ones and `lock` = 0: toggle `status`, set `lock`.
- When the register is all zeros: clear `lock`.
- A held button therefore toggles exactly once per press.

Una path:
- `una_irq` register ← `una_i`.
- `virq_o` = virq_i | una_irq.
- `vec_o` = una_i ? STARTUP : vec_i.
- FSM states: IDLE, WAIT, ACK, HOLD.
  - IDLE → WAIT on istb_i & una_i, loading counter with UNA_DLY−1.
  - WAIT counts down; at 0 → ACK.
  - ACK lasts 1 cycle → HOLD.
  - HOLD → IDLE when istb_i = 0.
- `iack_o` = iack_i | (state == ACK).
- Dropping istb_i or una_i in WAIT returns the FSM to IDLE with no ack.
- `vm_init_i` = 1 forces IDLE and `una_irq` = 0, with priority over all transitions.

## Timing
Reset values:
- cnt = 0, so `clk_ena_o` = 1.
- Synchronisers and `tstb` = 0; `evnt_o` = 0.
- Shift registers = 0, `lock` = 0, `status_o` = BTN_INIT.
- FSM IDLE, `una_irq` = 0, so `virq_o` = virq_i and `iack_o` = iack_i.

Latencies:
- `tstb` asserts on the 3rd clk_p edge after `tick_i` rises.
- `evnt_o` follows `tick_i` with 2-cycle latency.
- `status_o` changes the cycle after the DEB_LEN-th qualifying `tstb`.
- Una ack: iack_o pulses exactly 1 cycle, UNA_DLY+1 cycles after the first cycle with istb_i & una_i. It never re-pulses before istb_i drops.
- `virq_o` una component lags `una_i` by 1 cycle.

Boundary conditions:
- Simultaneous `tstb` and button release: the shift occurs, then the lock/toggle rule is evaluated on the new register value.
- Reset asserted mid-debounce or mid-ack: immediate return to reset values; no toggle or ack is produced.

## Test plan
- Divider: cpuslow=1, div_i=21 → clk_ena_o high 1 cycle in every 22. Change div_i to 3 while cnt=10 → cnt wraps next cycle, then period 4. cpuslow=0 → constant 1.
- Timer gate: NBTN=1, reset, 50 Hz square on tick_i → evnt_o mirrors tick_i delayed 2 cycles. Press btn for 3 ticks → status_o=0 after the 2nd tstb, evnt_o stays 0. Release for 2 ticks, press again → status_o=1.
- Debounce glitch: btn high for 1 tick only (DEB_LEN=2) → no toggle. Btn held for 10 ticks → exactly one toggle.
- Una: UNA_DLY=2, una_i=istb_i=1 held → vec_o=16'o140001, virq_o=1 from next cycle, iack_o single pulse 3 cycles later, no second pulse until istb_i low.
- Una abort/init: assert vm_init_i during WAIT → no iack_o, virq_o una part 0. With una_i=0, vec_o=vec_i and iack_o=iack_i pass through.
- Async reset: drop rst_n mid-count and mid-HOLD → all outputs at reset values in the same cycle, status_o=BTN_INIT.
